// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      entrada;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;

  modport master (
    output start, entrada,
    input  busy, done, bcd_out, overflow
  );

  modport slave (
    input  start, entrada,
    output busy, done, bcd_out, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift-and-add-3 iteration per clock.
// Results are published only at completion, so bcd_out/overflow never show
// partial values while a conversion is running.
module bin_to_bcd_seq #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 8,
  parameter int FULL_DIGITS = 10
) (
  input  logic             clock,
  input  logic             reset,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * FULL_DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_bin;
  logic [SW-1:0]        r_scratch;
  logic [CW-1:0]        r_count;
  logic                 r_busy;
  logic                 r_done;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_overflow;

  logic [SW-1:0]        w_adj;
  logic [SW-1:0]        w_next_scratch;

  // Add-3 correction on every digit >= 5, then shift in the next binary bit.
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned d = 0; d < FULL_DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
    w_next_scratch = {w_adj[SW-2:0], r_bin[WIDTH-1]};
  end

  // Control FSM with registered outputs; done is a single-cycle strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_bin     <= bus.entrada;
            r_scratch <= '0;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_scratch <= w_next_scratch;
          r_bin     <= {r_bin[WIDTH-2:0], 1'b0};
          r_count   <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1)) begin
            r_bcd      <= w_next_scratch[4*DIGITS-1:0];
            r_overflow <= |w_next_scratch[SW-1:4*DIGITS];
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.bcd_out  = r_bcd;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

  localparam int WIDTH = 32;
  localparam int DIGITS = 8;

  typedef struct {
    logic [31:0]  bcd;
    logic         ovf;
    int unsigned  cyc;
    logic [31:0]  val;
  } exp_t;

  logic clock;
  logic reset;
  int unsigned cyc;
  int unsigned next_free;
  int unsigned vectors;
  int unsigned miscompares;
  exp_t sb[$];

  bin_to_bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS), .FULL_DIGITS(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Decimal reference: digits of (v mod 10^8), overflow when v >= 10^8.
  function automatic exp_t model(input logic [31:0] v, input int unsigned c);
    exp_t e;
    longint unsigned x;
    x = longint'(v) % 64'd100000000;
    e.bcd = '0;
    for (int i = 0; i < 8; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.ovf = (longint'(v) > 64'd99999999);
    e.cyc = c;
    e.val = v;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 bcd=0x%08h required no done", bus.bcd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("bcd(%0d)", e.val), bus.bcd_out, e.bcd);
        check($sformatf("ovf(%0d)", e.val), 32'(bus.overflow), 32'(e.ovf));
        check($sformatf("latency(%0d)", e.val), cyc, e.cyc);
      end
    end
  end

  // Drives start for one cycle once the converter is known to be idle.
  task automatic start_conv(input logic [31:0] v, input bit track);
    @(negedge clock);
    while (cyc < next_free) @(negedge clock);
    bus.start   = 1'b1;
    bus.entrada = v;
    if (track) begin
      sb.push_back(model(v, cyc + 1 + WIDTH));
      next_free = cyc + 1 + WIDTH;
    end
    @(negedge clock);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic async_reset_check();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", bus.bcd_out, 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    next_free = cyc;
  endtask

  logic [31:0] rv;

  initial begin
    cyc = 0;
    next_free = 0;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.entrada = '0;
    #22 reset = 1'b0;

    // Directed values and boundaries.
    start_conv(32'd0, 1'b1);
    start_conv(32'd12345678, 1'b1);
    start_conv(32'd99999999, 1'b1);
    start_conv(32'd100000000, 1'b1);
    start_conv(32'hFFFFFFFF, 1'b1);
    drain();

    // Asynchronous reset while outputs hold a non-zero result.
    async_reset_check();

    // Start while busy is ignored.
    start_conv(32'd42, 1'b1);
    bus.start = 1'b1;
    bus.entrada = 32'd7;
    @(negedge clock);
    bus.start = 1'b0;
    // Start in the done cycle is accepted.
    start_conv(32'd305, 1'b1);
    drain();

    // Reset mid-conversion aborts without a done pulse.
    start_conv(32'd555, 1'b0);
    repeat (8) @(negedge clock);
    async_reset_check();
    repeat (40) @(negedge clock);
    start_conv(32'd9, 1'b1);
    drain();

    // Start held high: back-to-back conversions every WIDTH+1 cycles.
    @(negedge clock);
    next_free = cyc;
    bus.start = 1'b1;
    bus.entrada = 32'd271828;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(32'd271828, cyc + 1 + WIDTH));
      repeat (WIDTH + 1) @(negedge clock);
    end
    bus.start = 1'b0;
    next_free = cyc + WIDTH;
    drain();

    // Randomized values with random idle gaps (including none).
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0: rv = $urandom;
        1: rv = $urandom_range(0, 99999999);
        default: rv = 32'd99999990 + $urandom_range(0, 20);
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clock);
      start_conv(rv, 1'b1);
      // Changing entrada mid-conversion must not matter.
      bus.entrada = $urandom;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter that uses the shift-and-add-3 (double dabble) algorithm on a 32-bit unsigned value. It sits directly upstream of the 8-digit seven-segment decoder. It provides packed BCD digits and a completion strobe, so the decoder needs only a 4-bit-per-digit segment lookup and no wide combinational divide/modulo logic. It takes one iteration per clock and uses a start/done handshake.

Parameters:
WIDTH, 32, bit width of the binary input; number of shift iterations per conversion.
DIGITS, 8, number of BCD digits presented on bcd_out (4*DIGITS bits).
FULL_DIGITS, 10, internal BCD scratch digits; must be at least ceil(WIDTH*log10(2)), which gives 10 for WIDTH=32.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request conversion; sampled only in IDLE.
entrada  input  WIDTH  unsigned binary value; captured on the accepted start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd_out/overflow are updated.
bcd_out  output  4*DIGITS  packed BCD; digit i at bits [4i+3:4i], digit 0 = units.
overflow  output  1  entrada captured value exceeds 10^DIGITS-1 (99,999,999 for defaults).

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, bcd_out=0, overflow=0; shift register, scratch and iteration counter are cleared. Reset mid-conversion aborts it with no done pulse.
- Register-driven outputs only; none depend combinationally on inputs.
- States: IDLE, CONV.
- IDLE: when start=1 at edge k:
  - bin_reg <= entrada, scratch (4*FULL_DIGITS bits) <= 0, count <= 0, state <= CONV, busy <= 1 (visible after edge k).
- CONV, one iteration per edge:
  - Each scratch digit >= 5 gets +3 (evaluated on the current digits).
  - Then {scratch, bin_reg} shifts left by 1; the bin_reg MSB enters the scratch LSB.
  - count increments.
- Completion: at the edge that performs iteration WIDTH (count == WIDTH-1 before the edge, i.e. edge k+WIDTH):
  - bcd_out <= low DIGITS digits of the final scratch.
  - overflow <= OR of the upper (FULL_DIGITS-DIGITS) digits.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start accepted at edge k → done high in cycle after edge k+WIDTH (32 cycles for defaults); throughput one conversion per WIDTH+1 cycles.
- done is high for exactly one cycle; it is cleared on the next edge unless another completion occurs (impossible back-to-back).
- start while busy: ignored, with no queueing. start in the cycle done is high: accepted (state is already IDLE).
- start held high continuously: a new conversion begins each time IDLE is re-entered, i.e. back-to-back conversions every WIDTH+1 cycles.
- entrada changes during CONV: no effect; the value was captured at start.
- bcd_out/overflow hold their last completed result until the next completion; they are never partially updated during CONV.
- Overflow: bcd_out still shows the low DIGITS decimal digits (value mod 10^DIGITS).
- Every digit of bcd_out is always in 0..9.

Test Plan:
- Reset then idle: assert reset mid-cycle (asynchronous) → busy=0, done=0, bcd_out=0x00000000, overflow=0 immediately.
- Basic conversions, each sampled at the done pulse:
  - entrada=0 → bcd_out=0x00000000, overflow=0.
  - entrada=12345678 → bcd_out=0x12345678, overflow=0.
  - done appears exactly 32 cycles after the start edge.
- Boundary: entrada=99999999 → bcd_out=0x99999999, overflow=0; entrada=100000000 → bcd_out=0x00000000, overflow=1.
- Maximum input: entrada=0xFFFFFFFF (4294967295) → bcd_out=0x94967295, overflow=1.
- Handshake:
  - start=1 for one cycle with entrada=42, then pulse start with entrada=7 while busy → one done, bcd_out=0x00000042.
  - start asserted during the done cycle with entrada=305 → second done 32 cycles later, bcd_out=0x00000305.
- Reset mid-operation: start with entrada=555, assert reset after 10 cycles → no done pulse, outputs return to 0; a subsequent start with entrada=9 → bcd_out=0x00000009.
